// File: rtl/player_life_ctrl.sv
// player_life_ctrl: life-cycle sequencer for the player.
// It gates movement, times the death animation, counts lives, requests
// respawns to the start cell and flags game over.
// Ports:
//   clk, resetN            - clock, asynchronous active-low reset
//   startOfFrame           - one-cycle pulse per video frame
//   game_start             - one-cycle start/restart request
//   collision              - level-sensitive player-vs-enemy hit
//   extra_life             - one-cycle bonus-life pulse
//   player_enable          - movement allowed
//   respawn_pulse          - one-cycle request to reload the start position
//   invulnerable           - post-respawn immunity window active
//   death_frame[1:0]       - death animation phase 0..3
//   lives[2:0]             - remaining lives
//   game_over              - game-over flag
//   state[2:0]             - IDLE=0, PLAYING=1, DYING=2, GAME_OVER=3
// Every output is a register.
module player_life_ctrl #(
  parameter int INITIAL_LIVES = 3,
  parameter int MAX_LIVES     = 7,
  parameter int DEATH_FRAMES  = 64,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       game_start,
  input  logic       collision,
  input  logic       extra_life,
  output logic       player_enable,
  output logic       respawn_pulse,
  output logic       invulnerable,
  output logic [1:0] death_frame,
  output logic [2:0] lives,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_DYING     = 3'd2,
    ST_GAME_OVER = 3'd3
  } state_t;

  localparam logic [2:0] INIT_LIVES_C = 3'(INITIAL_LIVES);
  localparam logic [2:0] MAX_LIVES_C  = 3'(MAX_LIVES);
  localparam logic [7:0] DEATH_LAST_C = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] INVULN_C     = 8'(INVULN_FRAMES);
  // Phase is the top two bits of the log2(DEATH_FRAMES)-bit frame count.
  localparam int         DF_MSB       = $clog2(DEATH_FRAMES) - 1;

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] invuln_cnt_q, invuln_cnt_d;
  logic       respawn_d;
  logic [2:0] lives_inc_s;

  logic       player_enable_q, respawn_q, invuln_q, game_over_q;
  logic [1:0] death_frame_q;

  // Next-state, counter and lives computation.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    frame_cnt_d  = frame_cnt_q;
    invuln_cnt_d = invuln_cnt_q;
    respawn_d    = 1'b0;

    if (lives_q >= MAX_LIVES_C) begin
      lives_inc_s = MAX_LIVES_C;
    end else begin
      lives_inc_s = lives_q + 3'd1;
    end

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (game_start) begin
          state_d      = ST_PLAYING;
          lives_d      = INIT_LIVES_C;
          invuln_cnt_d = 8'd0;
          respawn_d    = 1'b1;
        end else begin
          state_d      = state_q;
        end
      end
      ST_PLAYING: begin
        if (startOfFrame && (invuln_cnt_q != 8'd0)) begin
          invuln_cnt_d = invuln_cnt_q - 8'd1;
        end else begin
          invuln_cnt_d = invuln_cnt_q;
        end
        if (collision && (invuln_cnt_q == 8'd0)) begin
          // The death wins over a coincident startOfFrame: frame_cnt starts at 0.
          state_d     = ST_DYING;
          frame_cnt_d = 8'd0;
          if (extra_life) begin
            lives_d = lives_q;            // bonus cancels the loss
          end else if (lives_q == 3'd0) begin
            lives_d = 3'd0;
          end else begin
            lives_d = lives_q - 3'd1;
          end
        end else if (extra_life) begin
          lives_d = lives_inc_s;
        end else begin
          lives_d = lives_q;
        end
      end
      ST_DYING: begin
        if (extra_life) begin
          lives_d = lives_inc_s;
        end else begin
          lives_d = lives_q;
        end
        if (startOfFrame) begin
          if (frame_cnt_q == DEATH_LAST_C) begin
            frame_cnt_d = 8'd0;
            // Uses the post-bonus count so a last-frame extra life respawns.
            if (lives_d == 3'd0) begin
              state_d = ST_GAME_OVER;
            end else begin
              state_d      = ST_PLAYING;
              respawn_d    = 1'b1;
              invuln_cnt_d = INVULN_C;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q         <= ST_IDLE;
      lives_q         <= INIT_LIVES_C;
      frame_cnt_q     <= 8'd0;
      invuln_cnt_q    <= 8'd0;
      player_enable_q <= 1'b0;
      respawn_q       <= 1'b0;
      invuln_q        <= 1'b0;
      death_frame_q   <= 2'd0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      lives_q         <= lives_d;
      frame_cnt_q     <= frame_cnt_d;
      invuln_cnt_q    <= invuln_cnt_d;
      player_enable_q <= (state_d == ST_PLAYING);
      respawn_q       <= respawn_d;
      invuln_q        <= (state_d == ST_PLAYING) && (invuln_cnt_d != 8'd0);
      death_frame_q   <= (state_d == ST_DYING) ? frame_cnt_d[DF_MSB -: 2] : 2'd0;
      game_over_q     <= (state_d == ST_GAME_OVER);
    end
  end

  assign state         = state_q;
  assign lives         = lives_q;
  assign player_enable = player_enable_q;
  assign respawn_pulse = respawn_q;
  assign invulnerable  = invuln_q;
  assign death_frame   = death_frame_q;
  assign game_over     = game_over_q;

endmodule
